// File: rtl/fetch_ctrl_if.sv
// Signal bundle between the fetch controller, instruction memory, decode and execute.
// master = fetch controller side, slave = memory/pipeline side.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    input  imem_ack, imem_rdata, inst_ready, branch_taken, branch_target, halt
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    output imem_ack, imem_rdata, inst_ready, branch_taken, branch_target, halt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller with branch redirect, halt and
// a one-entry hold register towards decode. Outputs depend only on state/registers.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INCR  = 32'd4
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, FLUSH, HOLD, HALTED} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] inst_out_reg, inst_out_next;
  logic [31:0] inst_pc_reg, inst_pc_next;
  logic [31:0] redirect_pc;

  assign redirect_pc = {bus.branch_target[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      addr_reg     <= RESET_PC;
      inst_out_reg <= 32'h0;
      inst_pc_reg  <= 32'h0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      addr_reg     <= addr_next;
      inst_out_reg <= inst_out_next;
      inst_pc_reg  <= inst_pc_next;
    end
  end

  // pc_next already carries any redirect seen this cycle, so "last redirect wins"
  // falls out naturally wherever a new fetch address is taken from it.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    addr_next     = addr_reg;
    inst_out_next = inst_out_reg;
    inst_pc_next  = inst_pc_reg;

    if (bus.branch_taken)
      pc_next = redirect_pc;

    case (state_reg)
      IDLE: begin
        if (bus.halt) begin
          state_next = HALTED;
        end else begin
          state_next = REQ;
          addr_next  = pc_next;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (bus.branch_taken) begin
            state_next = REQ;
            addr_next  = redirect_pc;
          end else begin
            inst_out_next = bus.imem_rdata;
            inst_pc_next  = addr_reg;
            pc_next       = addr_reg + PC_INCR;
            state_next    = HOLD;
          end
        end else if (bus.branch_taken) begin
          // Address stays on the bus until the stale fetch is acknowledged.
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.imem_ack) begin
          if (bus.halt) begin
            state_next = HALTED;
          end else begin
            state_next = REQ;
            addr_next  = pc_next;
          end
        end
      end
      HOLD: begin
        if (bus.branch_taken) begin
          state_next = REQ;
          addr_next  = redirect_pc;
        end else if (bus.inst_ready) begin
          if (bus.halt) begin
            state_next = HALTED;
          end else begin
            state_next = REQ;
            addr_next  = pc_next;
          end
        end
      end
      HALTED: begin
        if (!bus.halt) begin
          state_next = REQ;
          addr_next  = pc_next;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.imem_req   = (state_reg == REQ) || (state_reg == FLUSH);
  assign bus.imem_addr  = addr_reg;
  assign bus.inst_valid = (state_reg == HOLD);
  assign bus.inst_out   = inst_out_reg;
  assign bus.inst_pc    = inst_pc_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, sequential fetch, redirects, stall/halt,
// address wrap and reset during an outstanding fetch.
module tb_fetch_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .PC_INCR  (32'd4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-14s obs=%08h exp=%08h ok", tag, obs, exp);
    end else begin
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; outputs are stable there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset             = 1'b1;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = 32'h0;
    bus.inst_ready    = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.halt          = 1'b0;

    // Reset state
    step();
    check("rst_req",    {31'b0, bus.imem_req},   32'h0);
    check("rst_addr",   bus.imem_addr,           32'h0);
    check("rst_valid",  {31'b0, bus.inst_valid}, 32'h0);
    check("rst_inst",   bus.inst_out,            32'h0);
    check("rst_pc",     bus.inst_pc,             32'h0);
    reset = 1'b0;

    // First fetch after reset: IDLE -> REQ at address 0
    step();
    check("t1_req",     {31'b0, bus.imem_req},   32'h1);
    check("t1_addr",    bus.imem_addr,           32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hE3A0_0001; bus.inst_ready = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    check("t1_valid",   {31'b0, bus.inst_valid}, 32'h1);
    check("t1_inst",    bus.inst_out,            32'hE3A0_0001);
    check("t1_ipc",     bus.inst_pc,             32'h0);
    check("t1_noreq",   {31'b0, bus.imem_req},   32'h0);
    step();
    check("t1_valid0",  {31'b0, bus.inst_valid}, 32'h0);
    check("t1_next",    bus.imem_addr,           32'h4);
    check("t1_req2",    {31'b0, bus.imem_req},   32'h1);

    // Fetch 4, then fetch 8 and hold it
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_1111;
    step();
    bus.imem_ack = 1'b0;
    check("t2_ipc4",    bus.inst_pc,             32'h4);
    step();
    check("t2_addr8",   bus.imem_addr,           32'h8);
    bus.inst_ready = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2222_2222;
    step();
    bus.imem_ack = 1'b0;
    check("t2_hold",    {31'b0, bus.inst_valid}, 32'h1);
    check("t2_ipc8",    bus.inst_pc,             32'h8);
    // Redirect in HOLD with ready high: held word must be dropped
    bus.branch_taken = 1'b1; bus.branch_target = 32'h100; bus.inst_ready = 1'b1;
    step();
    bus.branch_taken = 1'b0; bus.inst_ready = 1'b0;
    check("t2_drop",    {31'b0, bus.inst_valid}, 32'h0);
    check("t2_addr",    bus.imem_addr,           32'h100);
    check("t2_req",     {31'b0, bus.imem_req},   32'h1);

    // Redirect coinciding with ack in REQ: word discarded, refetch at 12
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3333_3333;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_000C;
    step();
    bus.imem_ack = 1'b0; bus.branch_taken = 1'b0;
    check("t3_nvalid",  {31'b0, bus.inst_valid}, 32'h0);
    check("t3_addr12",  bus.imem_addr,           32'hC);
    // Redirect with fetch outstanding: address held until ack
    bus.branch_taken = 1'b1; bus.branch_target = 32'h203;
    step();
    bus.branch_taken = 1'b0;
    check("t3_flreq",   {31'b0, bus.imem_req},   32'h1);
    check("t3_fladdr",  bus.imem_addr,           32'hC);
    step();
    check("t3_fladdr2", bus.imem_addr,           32'hC);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_ack = 1'b0;
    check("t3_nvalid2", {31'b0, bus.inst_valid}, 32'h0);
    check("t3_addr200", bus.imem_addr,           32'h200);
    check("t3_req",     {31'b0, bus.imem_req},   32'h1);

    // Stall for 5 cycles, then halt, then resume
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hA5A5_0200;
    step();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4_sval",  {31'b0, bus.inst_valid}, 32'h1);
      check("t4_sinst", bus.inst_out,            32'hA5A5_0200);
      check("t4_spc",   bus.inst_pc,             32'h200);
      step();
    end
    bus.halt = 1'b1; bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    check("t4_hval",    {31'b0, bus.inst_valid}, 32'h0);
    check("t4_hreq",    {31'b0, bus.imem_req},   32'h0);
    step();
    check("t4_hreq2",   {31'b0, bus.imem_req},   32'h0);
    bus.halt = 1'b0;
    step();
    check("t4_rreq",    {31'b0, bus.imem_req},   32'h1);
    check("t4_raddr",   bus.imem_addr,           32'h204);

    // Wrap-around at top of address space
    bus.imem_ack = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'hFFFF_FFFC;
    step();
    bus.branch_taken = 1'b0;
    check("t5_top",     bus.imem_addr,           32'hFFFF_FFFC);
    bus.imem_rdata = 32'h5555_AAAA; bus.inst_ready = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    check("t5_ipc",     bus.inst_pc,             32'hFFFF_FFFC);
    step();
    check("t5_wrap",    bus.imem_addr,           32'h0);
    check("t5_req",     {31'b0, bus.imem_req},   32'h1);

    // Reach REQ at address 4, then reset mid-fetch
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h6666_6666;
    step();
    bus.imem_ack = 1'b0;
    step();
    check("t6_addr4",   bus.imem_addr,           32'h4);
    reset = 1'b1;
    #1;
    check("t6_rreq",    {31'b0, bus.imem_req},   32'h0);
    check("t6_rval",    {31'b0, bus.inst_valid}, 32'h0);
    check("t6_raddr",   bus.imem_addr,           32'h0);
    step();
    reset = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h7777_7777;
    step();
    bus.imem_ack = 1'b0;
    check("t6_lateval", {31'b0, bus.inst_valid}, 32'h0);
    check("t6_req",     {31'b0, bus.imem_req},   32'h1);
    check("t6_addr0",   bus.imem_addr,           32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h8888_8888;
    step();
    bus.imem_ack = 1'b0;
    check("t6_val",     {31'b0, bus.inst_valid}, 32'h1);
    check("t6_inst",    bus.inst_out,            32'h8888_8888);
    check("t6_ipc",     bus.inst_pc,             32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
